// File: rtl/x_stepper_pkg.sv
// Shared widths, fixed-point constants and FSM encoding for the x_stepper sweep generator.
package x_stepper_pkg;

    localparam int unsigned N_W       = 32;
    localparam int unsigned SW_W      = 16;
    localparam int unsigned FRAC_BITS = 16;

    localparam logic [N_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [N_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/x_stepper_step_addsub.sv
// Combinational signed +/- unsigned step with saturation to the signed W-bit range.
module step_addsub
    import x_stepper_pkg::*;
#(
    parameter int unsigned W = N_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] y_c,
    output logic         ovf_c
);

    // Two guard bits: b is unsigned, so |a +/- b| can exceed what one extra bit holds.
    localparam int unsigned XW = W + 2;

    logic [XW-1:0] a_ext;
    logic [XW-1:0] b_ext;
    logic [XW-1:0] sum;

    always_comb begin
        a_ext = {{2{a_i[W-1]}}, a_i};
        b_ext = {2'b00, b_i};
        sum   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf_c = (sum[XW-1:W-1] != {3{sum[XW-1]}});
        y_c   = sum[W-1:0];
        if (ovf_c) begin
            y_c = sum[XW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/x_stepper.sv
// Emits the sweep X_k = X_o +/- k*h for k = 0..N over a valid/ready handshake.
module x_stepper
    import x_stepper_pkg::*;
#(
    parameter int unsigned n  = N_W,
    parameter int unsigned SW = SW_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [n-1:0]  x0,
    input  logic [n-1:0]  h,
    input  logic          h_sign,
    input  logic [SW-1:0] steps,
    output logic [n-1:0]  x_out,
    output logic [SW-1:0] k_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    state_e        state_q, state_d;
    logic [n-1:0]  x_q, x_d;
    logic [n-1:0]  h_q, h_d;
    logic          sign_q, sign_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [SW-1:0] k_q, k_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic [n-1:0]  next_x_c;
    logic          next_ovf_c;
    logic          accept_c;

    step_addsub #(.W(n)) u_addsub (
        .a_i   (x_q),
        .b_i   (h_q),
        .sub_i (sign_q),
        .y_c   (next_x_c),
        .ovf_c (next_ovf_c)
    );

    assign accept_c = out_valid_q & out_ready;

    // Next-state and next-output logic; outputs follow the next state so they are registered.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        sign_d  = sign_q;
        steps_d = steps_q;
        k_d     = k_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = x0;
                    h_d     = h;
                    sign_d  = h_sign;
                    steps_d = steps;
                    k_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept_c) begin
                    if (k_q == steps_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        x_d   = next_x_c;
                        k_d   = k_q + SW'(1);
                        ovf_d = ovf_q | next_ovf_c;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        out_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            h_q         <= '0;
            sign_q      <= 1'b0;
            steps_q     <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            h_q         <= h_d;
            sign_q      <= sign_d;
            steps_q     <= steps_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign x_out     = x_q;
    assign k_out     = k_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule
